masked_share_encoder: RTL
=========================

Name: masked_share_encoder

Overview:
- Source end of the 2-share masked datapath: takes plaintext operands a and b, splits each into Boolean shares (x0 = x ^ m, x1 = m) using fresh LFSR masks, and supplies the gadget randomness r.
- Outputs feed the masked XOR gadget and its registered wrapper.
- Valid/ready handshake on both sides, one output register stage.
- Reseed port so benches and the system can set the mask sequence to a known state.

Parameters:
- WIDTH, 1, bits per plaintext operand (shares are WIDTH bits each).
- SEED, 16'hACE1, LFSR value after reset and the lock-up recovery value.
- Constraint: 2*WIDTH+3 <= 16. Elaboration fails otherwise.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext offered
- in_ready  out  1  plaintext accepted this cycle when in_valid && in_ready
- a  in  WIDTH  plaintext operand A
- b  in  WIDTH  plaintext operand B
- out_valid  out  1  share bundle valid
- out_ready  in  1  downstream accepts bundle
- A0, A1, B0, B1  out  WIDTH each  shares; A0^A1 == a, B0^B1 == b
- r  out  3  fresh gadget randomness {r2,r1,r0}
- reseed_valid  in  1  load new LFSR state
- reseed_value  in  16  new LFSR state
- tx_count  out  16  number of accepted input transfers, wraps modulo 2^16

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0; A0/A1/B0/B1/r=0; tx_count=0; lfsr=SEED.
  - Reset mid-transfer drops any held bundle with no output.
- in_ready = !out_valid || out_ready. This is combinational, giving full throughput of one bundle per cycle.
- LFSR:
  - 16-bit Fibonacci, fb = s[15]^s[13]^s[12]^s[10], next = {s[14:0], fb}.
  - Advances only on an accepted input transfer, so the mask sequence depends on the transfer count and not on stalls.
- Mask slicing from the current state s on an accepted transfer:
  - mA = s[WIDTH-1:0]
  - mB = s[2W-1:W]
  - rr = s[2W+2:2W]
- Registered on acceptance (latency 1 cycle from accept to out_valid=1):
  - A0<=a^mA, A1<=mA, B0<=b^mB, B1<=mB, r<=rr, out_valid<=1.
- out_valid clears when out_ready && !(in_valid && in_ready).
- Output stability: while out_valid && !out_ready, all outputs are held stable and no input is accepted.
- Reseed handling:
  - reseed_valid has priority over advance. The state becomes reseed_value, or SEED if reseed_value==0 (lock-up guard).
  - If a transfer is accepted in the same cycle, the bundle uses the pre-reseed state.
- Any masking that ends in an all-zero state (via reseed) is forced to SEED. The LFSR never holds 0.
- tx_count increments on each accepted transfer and wraps from 16'hFFFF to 0.
- Simultaneous events:
  - Accept with out_ready=1 gives back-to-back bundles with no bubble.
  - Reset together with reseed_valid: reset wins.
- Leakage rule: a, mA and mB never combine in any wire except the single XOR per share bit. No output depends on the unmasked a or b alone.

Decomposition:
- masked_pkg:
  - LFSR_W=16, DEFAULT_SEED=16'hACE1, the tap positions, R_W=3.
  - Helper function lfsr_next(s).
- Sub-module: share_lfsr (state register, reseed/zero guard, advance enable), instantiated once. Slicing and share registers stay in the top level.

Test Plan:
- Reset, then WIDTH=2, a=2'b10, b=2'b01, in_valid=1, out_ready=1 → next cycle out_valid=1, A0=2'b11, A1=2'b01, B0=2'b01, B1=2'b00, r=3'b110. lfsr becomes 16'h59C3; tx_count=1.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, outputs frozen, lfsr stays 16'h59C3. Release gives exactly one new bundle per cycle.
- Reseed with reseed_value=0 → lfsr=16'hACE1. Reseed with 16'h1234 concurrent with a transfer → that bundle uses the old state; the following bundle uses slices of 16'h1234.
- 1000 random transfers with random out_ready → A0^A1==a and B0^B1==b for every bundle. No bundle is lost or duplicated, checked by scoreboard and by tx_count.
- Assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, tx_count=0, lfsr=16'hACE1.
- Preload tx_count near wrap with 65536 transfers → tx_count returns to 0.

Source files
------------

// File: rtl/masked_pkg.sv
// Shared constants and LFSR step for the 2-share masked datapath source.
package masked_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam int TAP0 = 15;
  localparam int TAP1 = 13;
  localparam int TAP2 = 12;
  localparam int TAP3 = 10;
  localparam int R_W = 3;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
    return {s[LFSR_W-2:0], fb};
  endfunction
endpackage

// File: rtl/share_lfsr.sv
// Mask source LFSR: steps only on accepted transfers, reseedable, never holds zero.
module share_lfsr
  import masked_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              adv_i,
  input  logic              reseed_vld_i,
  input  logic [LFSR_W-1:0] reseed_dat_i,
  output logic [LFSR_W-1:0] state_o
);
  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (reseed_vld_i) begin
      state_d = reseed_dat_i;
    end else if (adv_i) begin
      state_d = lfsr_next(state_q);
    end
    // All-zero is the lock-up state of this LFSR; recover to the seed.
    if (state_d == '0) begin
      state_d = SEED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/masked_share_encoder.sv
// Splits plaintext a/b into Boolean shares with fresh LFSR masks plus gadget randomness.
// One output register stage; in_ready = !out_valid || out_ready, full throughput.
module masked_share_encoder
  import masked_pkg::*;
#(
  parameter int              WIDTH = 1,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  A0,
  output logic [WIDTH-1:0]  A1,
  output logic [WIDTH-1:0]  B0,
  output logic [WIDTH-1:0]  B1,
  output logic [R_W-1:0]    r,
  input  logic              reseed_valid,
  input  logic [LFSR_W-1:0] reseed_value,
  output logic [15:0]       tx_count
);
  generate
    if (2 * WIDTH + R_W > LFSR_W) begin : g_width_check
      $error("masked_share_encoder: 2*WIDTH+3 must not exceed 16");
    end
  endgenerate

  logic              accept;
  logic [LFSR_W-1:0] lfsr_s;
  logic              unused_lfsr;
  logic [WIDTH-1:0]  m_a, m_b;
  logic [R_W-1:0]    rr;

  logic              out_valid_q;
  logic [WIDTH-1:0]  a0_q, a1_q, b0_q, b1_q;
  logic [R_W-1:0]    r_q;
  logic [15:0]       tx_count_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  share_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i        (clk),
    .rst_i        (rst),
    .adv_i        (accept),
    .reseed_vld_i (reseed_valid),
    .reseed_dat_i (reseed_value),
    .state_o      (lfsr_s)
  );

  // Upper state bits are not sliced for masks at small WIDTH.
  assign unused_lfsr = ^lfsr_s;
  assign m_a = lfsr_s[WIDTH-1:0];
  assign m_b = lfsr_s[2*WIDTH-1:WIDTH];
  assign rr  = lfsr_s[2*WIDTH+R_W-1:2*WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a0_q        <= '0;
      a1_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      r_q         <= '0;
      tx_count_q  <= '0;
    end else if (accept) begin
      // Plaintext meets its mask only in this one XOR per share bit.
      a0_q        <= a ^ m_a;
      a1_q        <= m_a;
      b0_q        <= b ^ m_b;
      b1_q        <= m_b;
      r_q         <= rr;
      out_valid_q <= 1'b1;
      tx_count_q  <= tx_count_q + 16'd1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign A0        = a0_q;
  assign A1        = a1_q;
  assign B0        = b0_q;
  assign B1        = b1_q;
  assign r         = r_q;
  assign tx_count  = tx_count_q;
endmodule
